// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one fixed-latency ALU between two requesters
module alu_arbiter #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic [1:0]  resp_valid,
   output logic [31:0] resp_result,
   output logic        resp_zero
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);
   state_t state, state_nx;
   logic [2:0] cnt;
   logic last, gid, gnt, hs, cap;
   // on a tie the requester not granted last wins, otherwise whoever is asking
   assign gnt = (req0_valid & req1_valid) ? ~last : req1_valid;
   // ready is gated by reset so nothing is offered while the block is held in reset
   assign req0_ready = hs & rst & ~gnt;
   assign req1_ready = hs & rst & gnt;
   assign resp_valid = (state == DONE) ? {gid, ~gid} : 2'b00;
   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   // next state, handshake and capture strobes
   always_comb begin
      state_nx = state;
      hs = 1'b0;
      cap = 1'b0;
      case (state)
         IDLE: if (req0_valid | req1_valid) begin
            hs = 1'b1;
            state_nx = EXEC;
         end
         EXEC: if (cnt == CNT_LAST) begin
            cap = 1'b1;
            state_nx = DONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // EXEC cycle counter, cleared whenever the ALU is not busy
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= 3'd0;
      else cnt <= (state == EXEC && !cap) ? cnt + 3'd1 : 3'd0;
   // latch the granted operation so the ALU sees stable inputs through EXEC
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         alu_a <= 32'd0;
         alu_b <= 32'd0;
         alu_op <= 3'b000;
         gid <= 1'b0;
         last <= 1'b1;
      end else if (hs) begin
         alu_a <= gnt ? req1_a : req0_a;
         alu_b <= gnt ? req1_b : req0_b;
         alu_op <= gnt ? req1_op : req0_op;
         gid <= gnt;
         last <= gnt;
      end
   // capture the ALU result on the last EXEC cycle and hold it until the next one
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         resp_result <= 32'd0;
         resp_zero <= 1'b0;
      end else if (cap) begin
         resp_result <= alu_result;
         resp_zero <= alu_zero;
      end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter at ALU_LAT=1 plus a directed ALU_LAT=3 check
module tb_alu_arbiter;
   localparam int LAT = 1;
   typedef struct {
      logic [1:0]  id;
      logic [31:0] res;
      logic        z;
      int          t;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   exp_t q[$];
   logic v0 = 0, v1 = 0;
   logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic [2:0] o0 = 0, o1 = 0;
   logic r0, r1, rz, xzero;
   logic [31:0] xa, xb, xres, rres;
   logic [2:0] xop;
   logic [1:0] rv;
   logic pv = 0;
   logic [31:0] pa = 0, pb = 0;
   logic [2:0] po = 0;
   logic p_r0, p_r1, p_rz, yzero;
   logic [31:0] ya, yb, yres, p_rres, s1, s2;
   logic [2:0] yop;
   logic [1:0] p_rv;
   logic p_v1 = 0;
   logic [31:0] p_zero32 = 0;
   logic [2:0] p_zero3 = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return a + b;
         3'b110: return a - b;
         3'b111: return {31'd0, $signed(a) < $signed(b)};
         default: return 32'd0;
      endcase
   endfunction
   assign xres = alu_f(xa, xb, xop);
   assign xzero = (xres == 32'd0);
   always @(posedge clk) begin
      s1 <= alu_f(ya, yb, yop);
      s2 <= s1;
   end
   assign yres = s2;
   assign yzero = (s2 == 32'd0);
   alu_arbiter #(.ALU_LAT(LAT)) u0 (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req1_valid(v1), .req0_ready(r0), .req1_ready(r1),
      .req0_a(a0), .req0_b(b0), .req0_op(o0), .req1_a(a1), .req1_b(b1), .req1_op(o1),
      .alu_a(xa), .alu_b(xb), .alu_op(xop), .alu_result(xres), .alu_zero(xzero),
      .resp_valid(rv), .resp_result(rres), .resp_zero(rz)
   );
   alu_arbiter #(.ALU_LAT(3)) u1 (
      .clk(clk), .rst(rst),
      .req0_valid(pv), .req1_valid(p_v1), .req0_ready(p_r0), .req1_ready(p_r1),
      .req0_a(pa), .req0_b(pb), .req0_op(po), .req1_a(p_zero32), .req1_b(p_zero32), .req1_op(p_zero3),
      .alu_a(ya), .alu_b(yb), .alu_op(yop), .alu_result(yres), .alu_zero(yzero),
      .resp_valid(p_rv), .resp_result(p_rres), .resp_zero(p_rz)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask
   task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] res, output int hs);
      int k = 0;
      @(negedge clk);
      if (id) begin v1 = 1; a1 = a; b1 = b; o1 = op; end
      else begin v0 = 1; a0 = a; b0 = b; o0 = op; end
      #1;
      while (!(id ? r1 : r0) && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_cmp++;
      if (k >= 50) begin
         n_bad++;
         $display("FAIL ready_timeout: req%0d got no ready want ready within 50 cycles", id);
         hs = -1;
         if (id) v1 = 0; else v0 = 0;
         return;
      end
      hs = cyc + 1;
      q.push_back('{id ? 2'b10 : 2'b01, res, res == 32'd0, hs + LAT});
      @(posedge clk);
      #1;
      if (id) begin v1 = 0; a1 = 32'd99; end
      else begin v0 = 0; a0 = 32'd99; end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (r0 && r1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_onehot: got ready %b%b want at most one high", r1, r0);
      end
      if (rst && rv != 2'b00) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got resp_valid %b want none", rv);
         end else begin
            e = q.pop_front();
            chk("resp_valid", 32'(rv), 32'(e.id));
            chk("resp_result", rres, e.res);
            chk("resp_zero", 32'(rz), 32'(e.z));
            chk("resp_cycle", 32'(cyc), 32'(e.t));
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish before 100us");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end
   initial begin
      int h, h0, h1, c;
      repeat (2) @(negedge clk);
      v0 = 1;
      #1;
      chk("rst_ready0", 32'(r0), 32'd0);
      chk("rst_resp_valid", 32'(rv), 32'd0);
      chk("rst_resp_result", rres, 32'd0);
      chk("rst_resp_zero", 32'(rz), 32'd0);
      chk("rst_alu_a", xa, 32'd0);
      chk("rst_alu_op", 32'(xop), 32'd0);
      @(negedge clk);
      rst = 1;
      v0 = 1; a0 = 1; b0 = 1; o0 = 3'b010;
      v1 = 1; a1 = 10; b1 = 3; o1 = 3'b110;
      c = cyc;
      for (int k = 0; k < 4; k++)
         q.push_back('{(k % 2 == 1) ? 2'b10 : 2'b01, (k % 2 == 1) ? 32'd7 : 32'd2, 1'b0, c + 1 + LAT + k * (LAT + 2)});
      #1;
      chk("tie_first_ready0", 32'(r0), 32'd1);
      chk("tie_first_ready1", 32'(r1), 32'd0);
      while (cyc < c + 1 + 3 * (LAT + 2)) @(negedge clk);
      v0 = 0;
      v1 = 0;
      repeat (5) @(negedge clk);
      chk("tie_drain", 32'(q.size()), 32'd0);
      issue(0, 32'd2, 32'd13, 3'b010, 32'd15, h);
      issue(1, 32'd5, 32'd5, 3'b110, 32'd0, h);
      repeat (5) @(negedge clk);
      chk("hold_result", rres, 32'd0);
      chk("hold_zero", 32'(rz), 32'd1);
      fork
         issue(1, 32'd20, 32'd22, 3'b001, 32'd22, h1);
         begin
            @(negedge clk);
            issue(0, 32'h0000_f0f0, 32'h0000_0ff0, 3'b000, 32'h0000_00f0, h0);
         end
      join
      chk("held_off_hs_cycle", 32'(h0), 32'(h1 + LAT + 2));
      issue(0, -32'sd3, 32'd2, 3'b111, 32'd1, h);
      fork
         issue(0, 32'd3, 32'd4, 3'b001, 32'd7, h);
         begin
            repeat (2) @(negedge clk);
            v1 = 1; a1 = 32'd1; b1 = 32'd1; o1 = 3'b010;
            #1;
            chk("busy_ready1", 32'(r1), 32'd0);
            @(negedge clk);
            v1 = 0;
         end
      join
      repeat (4) @(negedge clk);
      chk("no_serve_drain", 32'(q.size()), 32'd0);
      v0 = 1; a0 = 32'd7; b0 = 32'd9; o0 = 3'b010;
      #1;
      chk("abort_ready0", 32'(r0), 32'd1);
      @(posedge clk);
      #1;
      v0 = 0;
      a0 = 32'd99;
      #2;
      rst = 0;
      v1 = 1;
      #1;
      chk("abort_ready1", 32'(r1), 32'd0);
      chk("abort_resp_valid", 32'(rv), 32'd0);
      chk("abort_resp_result", rres, 32'd0);
      chk("abort_resp_zero", 32'(rz), 32'd0);
      chk("abort_alu_a", xa, 32'd0);
      chk("abort_alu_b", xb, 32'd0);
      chk("abort_alu_op", 32'(xop), 32'd0);
      @(negedge clk);
      v1 = 0;
      @(negedge clk);
      rst = 1;
      repeat (3) @(negedge clk);
      issue(0, 32'd40, 32'd2, 3'b110, 32'd38, h);
      repeat (4) @(negedge clk);
      chk("final_drain", 32'(q.size()), 32'd0);
      pv = 1; pa = 32'd7; pb = 32'd8; po = 3'b010;
      #1;
      chk("lat3_ready", 32'(p_r0), 32'd1);
      @(posedge clk);
      #1;
      h = cyc;
      pv = 0;
      pa = 32'd99;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("lat3_cycle", 32'(cyc), 32'(h + k));
         chk("lat3_alu_a", ya, 32'd7);
         chk("lat3_alu_op", 32'(yop), 32'd2);
         chk("lat3_resp_valid", 32'(p_rv), (k == 3) ? 32'd1 : 32'd0);
      end
      chk("lat3_resp_result", p_rres, 32'd15);
      chk("lat3_resp_zero", 32'(p_rz), 32'd0);
      @(negedge clk);
      chk("lat3_resp_pulse", 32'(p_rv), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
